// File: rtl/sam_bus_master.sv
// Initiator for the SAM3U parallel register bus: address-latch cycle followed by
// a burst of read or write byte strobes with parameterised setup/strobe/hold timing.
module sam_bus_master #(
    parameter int pSETUP  = 1,
    parameter int pSTROBE = 2,
    parameter int pHOLD   = 1,
    parameter int pTURN   = 1
) (
    input  logic        clk_usb,
    input  logic        reset_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic [7:0]  USB_Addr,
    output logic [7:0]  USB_D_out,
    output logic        USB_D_oe,
    input  logic [7:0]  USB_D_in,
    output logic        USB_ALEn,
    output logic        USB_CEn,
    output logic        USB_RDn,
    output logic        USB_WRn
);

    typedef enum logic [3:0] {
        S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD, S_WAIT_DATA,
        S_D_SETUP, S_D_STROBE, S_D_HOLD, S_TURN
    } state_t;

    // Phase counter is loaded with (duration - 1) and the phase ends when it reaches zero.
    localparam logic [15:0] SETUP_LD  = 16'(pSETUP - 1);
    localparam logic [15:0] STROBE_LD = 16'(pSTROBE - 1);
    localparam logic [15:0] HOLD_LD   = 16'(pHOLD - 1);
    localparam logic [15:0] TURN_LD   = 16'(pTURN - 1);

    state_t      state_reg, state_next;
    logic [15:0] phase_cnt_reg, phase_cnt_next;
    logic [15:0] bytes_reg, bytes_next;
    logic        write_reg;
    logic [7:0]  addr_reg;
    logic [7:0]  dout_reg;
    logic [7:0]  rd_data_reg;
    logic        rd_valid_reg, rd_valid_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        cen_reg, cen_next;
    logic        ale_reg, ale_next;
    logic        rdn_reg, rdn_next;
    logic        wrn_reg, wrn_next;
    logic        oe_reg, oe_next;
    logic        phase_end;
    logic        cmd_accept;
    logic        wr_accept;

    assign cmd_ready  = (state_reg == S_IDLE);
    assign wr_ready   = (state_reg == S_WAIT_DATA);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign wr_accept  = wr_valid && wr_ready;
    assign phase_end  = (phase_cnt_reg == 16'd0);

    // State register
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            state_reg     <= S_IDLE;
            phase_cnt_reg <= 16'd0;
            bytes_reg     <= 16'd0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            bytes_reg     <= bytes_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg - 16'd1;
        bytes_next     = bytes_reg;
        case (state_reg)
            S_IDLE: begin
                phase_cnt_next = phase_cnt_reg;
                if (cmd_valid) begin
                    state_next     = S_A_SETUP;
                    phase_cnt_next = SETUP_LD;
                    bytes_next     = cmd_len;
                end
            end
            S_A_SETUP: if (phase_end) begin
                state_next     = S_A_STROBE;
                phase_cnt_next = STROBE_LD;
            end
            S_A_STROBE: if (phase_end) begin
                state_next     = S_A_HOLD;
                phase_cnt_next = HOLD_LD;
            end
            S_A_HOLD: if (phase_end) begin
                if (bytes_reg == 16'd0) begin
                    state_next     = S_TURN;
                    phase_cnt_next = TURN_LD;
                end else if (write_reg) begin
                    state_next     = S_WAIT_DATA;
                    phase_cnt_next = phase_cnt_reg;
                end else begin
                    state_next     = S_D_SETUP;
                    phase_cnt_next = SETUP_LD;
                end
            end
            S_WAIT_DATA: begin
                phase_cnt_next = phase_cnt_reg;
                if (wr_valid) begin
                    state_next     = S_D_SETUP;
                    phase_cnt_next = SETUP_LD;
                end
            end
            S_D_SETUP: if (phase_end) begin
                state_next     = S_D_STROBE;
                phase_cnt_next = STROBE_LD;
            end
            S_D_STROBE: if (phase_end) begin
                state_next     = S_D_HOLD;
                phase_cnt_next = HOLD_LD;
            end
            S_D_HOLD: if (phase_end) begin
                if (bytes_reg != 16'd0)
                    bytes_next = bytes_reg - 16'd1;
                if (bytes_reg <= 16'd1) begin
                    state_next     = S_TURN;
                    phase_cnt_next = TURN_LD;
                end else if (write_reg) begin
                    state_next     = S_WAIT_DATA;
                    phase_cnt_next = phase_cnt_reg;
                end else begin
                    state_next     = S_D_SETUP;
                    phase_cnt_next = SETUP_LD;
                end
            end
            S_TURN: if (phase_end) begin
                state_next     = S_IDLE;
                phase_cnt_next = 16'd0;
            end
            default: begin
                state_next     = S_IDLE;
                phase_cnt_next = 16'd0;
            end
        endcase
    end

    // Output logic: decoded from the upcoming state so the registered pins line up with it.
    always_comb begin
        cen_next      = 1'b1;
        ale_next      = 1'b1;
        rdn_next      = 1'b1;
        wrn_next      = 1'b1;
        oe_next       = 1'b0;
        busy_next     = (state_next != S_IDLE);
        done_next     = (state_next == S_TURN) && (state_reg != S_TURN);
        rd_valid_next = (state_reg == S_D_STROBE) && (state_next == S_D_HOLD) && !write_reg;
        case (state_next)
            S_A_SETUP, S_A_HOLD, S_WAIT_DATA: cen_next = 1'b0;
            S_A_STROBE: begin
                cen_next = 1'b0;
                ale_next = 1'b0;
            end
            S_D_SETUP, S_D_HOLD: begin
                cen_next = 1'b0;
                oe_next  = write_reg;
            end
            S_D_STROBE: begin
                cen_next = 1'b0;
                oe_next  = write_reg;
                wrn_next = !write_reg;
                rdn_next = write_reg;
            end
            default: ;
        endcase
    end

    // Registered outputs and captured transaction data
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            write_reg    <= 1'b0;
            addr_reg     <= 8'd0;
            dout_reg     <= 8'd0;
            rd_data_reg  <= 8'd0;
            rd_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            cen_reg      <= 1'b1;
            ale_reg      <= 1'b1;
            rdn_reg      <= 1'b1;
            wrn_reg      <= 1'b1;
            oe_reg       <= 1'b0;
        end else begin
            if (cmd_accept) begin
                write_reg <= cmd_write;
                addr_reg  <= cmd_addr;
            end
            if (wr_accept)
                dout_reg <= wr_data;
            if (rd_valid_next)
                rd_data_reg <= USB_D_in;
            rd_valid_reg <= rd_valid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            cen_reg      <= cen_next;
            ale_reg      <= ale_next;
            rdn_reg      <= rdn_next;
            wrn_reg      <= wrn_next;
            oe_reg       <= oe_next;
        end
    end

    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign USB_Addr  = addr_reg;
    assign USB_D_out = dout_reg;
    assign USB_D_oe  = oe_reg;
    assign USB_ALEn  = ale_reg;
    assign USB_CEn   = cen_reg;
    assign USB_RDn   = rdn_reg;
    assign USB_WRn   = wrn_reg;

endmodule

// File: tb/tb_sam_bus_master.sv
// Directed bench for sam_bus_master at default timing; cycle k counts clk_usb edges after accept.
module tb_sam_bus_master;

    logic        clk_usb = 1'b0;
    logic        reset_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [7:0]  USB_Addr;
    logic [7:0]  USB_D_out;
    logic        USB_D_oe;
    logic [7:0]  USB_D_in;
    logic        USB_ALEn;
    logic        USB_CEn;
    logic        USB_RDn;
    logic        USB_WRn;

    int checks = 0;
    int errors = 0;

    sam_bus_master dut (
        .clk_usb   (clk_usb),
        .reset_i   (reset_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .USB_Addr  (USB_Addr),
        .USB_D_out (USB_D_out),
        .USB_D_oe  (USB_D_oe),
        .USB_D_in  (USB_D_in),
        .USB_ALEn  (USB_ALEn),
        .USB_CEn   (USB_CEn),
        .USB_RDn   (USB_RDn),
        .USB_WRn   (USB_WRn)
    );

    always #5 clk_usb = ~clk_usb;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input string tag, input logic cen, input logic ale,
                       input logic rdn, input logic wrn, input logic oe);
        check({tag, " cen"}, 16'(USB_CEn), 16'(cen));
        check({tag, " ale"}, 16'(USB_ALEn), 16'(ale));
        check({tag, " rdn"}, 16'(USB_RDn), 16'(rdn));
        check({tag, " wrn"}, 16'(USB_WRn), 16'(wrn));
        check({tag, " oe"}, 16'(USB_D_oe), 16'(oe));
        check({tag, " excl"}, 16'(!(USB_RDn == 1'b0 && USB_WRn == 1'b0) &&
              !(USB_ALEn == 1'b0 && (USB_RDn == 1'b0 || USB_WRn == 1'b0))), 16'd1);
    endtask

    // Called just after a negedge; returns #1 after the accepting edge.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [15:0] len);
        check("issue cmd_ready", 16'(cmd_ready), 16'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        @(posedge clk_usb);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 8'hFF;
        cmd_len   = 16'hFFFF;
    endtask

    task automatic run_len0(input logic [7:0] addr);
        string t;
        issue(1'b0, addr, 16'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_usb);
            t = $sformatf("len0 c%0d", k);
            bus(t, !(k <= 4), !(k == 2 || k == 3), 1'b1, 1'b1, 1'b0);
            check({t, " done"}, 16'(done), 16'(k == 5));
            check({t, " ready"}, 16'(cmd_ready), 16'(k == 6));
            if (k == 1) check({t, " addr"}, 16'(USB_Addr), 16'(addr));
        end
        $display("len0 addr=0x%0h done", addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string t;
        reset_i   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_len   = 16'd0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        USB_D_in  = 8'h00;
        repeat (2) @(negedge clk_usb);
        reset_i = 1'b0;
        @(negedge clk_usb);

        // Reset state
        bus("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("reset ready", 16'(cmd_ready), 16'd1);
        check("reset busy", 16'(busy), 16'd0);
        check("reset done", 16'(done), 16'd0);
        check("reset addr", 16'(USB_Addr), 16'd0);
        check("reset dout", 16'(USB_D_out), 16'd0);
        check("reset rd_data", 16'(rd_data), 16'd0);
        $display("reset state checked");

        // Write 0x2A, two bytes, wr_valid held high
        wr_valid = 1'b1;
        wr_data  = 8'h11;
        issue(1'b1, 8'h2A, 16'd2);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_usb);
            t = $sformatf("wr c%0d", k);
            bus(t, !(k <= 14), !(k == 2 || k == 3), 1'b1,
                !(k == 7 || k == 8 || k == 12 || k == 13),
                (k >= 6 && k <= 9) || (k >= 11 && k <= 14));
            check({t, " wr_ready"}, 16'(wr_ready), 16'(k == 5 || k == 10));
            check({t, " done"}, 16'(done), 16'(k == 15));
            check({t, " busy"}, 16'(busy), 16'(k <= 15));
            check({t, " ready"}, 16'(cmd_ready), 16'(k == 16));
            check({t, " rd_valid"}, 16'(rd_valid), 16'd0);
            if (k == 7 || k == 8) check({t, " dout"}, 16'(USB_D_out), 16'h11);
            if (k == 12 || k == 13) check({t, " dout"}, 16'(USB_D_out), 16'h22);
            if (k == 1) check({t, " addr"}, 16'(USB_Addr), 16'h2A);
            if (k == 15) check({t, " addr held"}, 16'(USB_Addr), 16'h2A);
            if (k == 6) wr_data = 8'h22;
        end
        wr_valid = 1'b0;
        $display("write addr=0x2A len=2 done");

        // Read 0x05, one byte
        USB_D_in = 8'hA5;
        issue(1'b0, 8'h05, 16'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_usb);
            t = $sformatf("rd c%0d", k);
            bus(t, !(k <= 8), !(k == 2 || k == 3), !(k == 6 || k == 7), 1'b1, 1'b0);
            check({t, " rd_valid"}, 16'(rd_valid), 16'(k == 8));
            check({t, " done"}, 16'(done), 16'(k == 9));
            check({t, " ready"}, 16'(cmd_ready), 16'(k == 10));
            if (k == 8) check({t, " rd_data"}, 16'(rd_data), 16'hA5);
            if (k == 8) USB_D_in = 8'h3C;
        end
        check("rd data held", 16'(rd_data), 16'hA5);
        $display("read addr=0x05 len=1 data=0x%0h", rd_data);

        // Write with wr_valid withheld for 10 cycles of WAIT_DATA
        wr_data = 8'h5C;
        issue(1'b1, 8'h40, 16'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_usb);
            t = $sformatf("stall c%0d", k);
            bus(t, !(k <= 18), !(k == 2 || k == 3), 1'b1,
                !(k == 16 || k == 17), k >= 15 && k <= 18);
            check({t, " wr_ready"}, 16'(wr_ready), 16'(k >= 5 && k <= 14));
            check({t, " done"}, 16'(done), 16'(k == 19));
            if (k == 16 || k == 17) check({t, " dout"}, 16'(USB_D_out), 16'h5C);
            if (k == 14) wr_valid = 1'b1;
            if (k == 15) wr_valid = 1'b0;
        end
        $display("stalled write addr=0x40 done");

        // Reset while the write strobe is low
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        issue(1'b1, 8'h66, 16'd1);
        for (int k = 1; k <= 7; k++) @(negedge clk_usb);
        check("rst mid wrn low", 16'(USB_WRn), 16'd0);
        reset_i = 1'b1;
        wr_valid = 1'b0;
        @(negedge clk_usb);
        reset_i = 1'b0;
        bus("rst mid", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst mid done", 16'(done), 16'd0);
        check("rst mid busy", 16'(busy), 16'd0);
        check("rst mid ready", 16'(cmd_ready), 16'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_usb);
            check($sformatf("rst after c%0d done", k), 16'(done), 16'd0);
        end
        $display("reset mid-write checked");

        // Address-only transaction after the reset
        run_len0(8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sam_bus_master.md
Name: sam_bus_master

Overview:
- Initiator side of the SAM3U-to-FPGA parallel register bus (USB_D / USB_Addr / USB_ALEn / USB_CEn / USB_RDn / USB_WRn).
- Accepts transaction commands (address, direction, byte count) and generates the address-latch cycle, then a run of read or write byte strobes with programmable setup/strobe/hold timing.
- Used as the bus-functional master for block-level benches of the register interface, and as an on-FPGA bridge when an internal agent must drive that bus.
- Bus data is split into out, output-enable and in; the tristate is resolved at top level.

Parameters:
pSETUP, 1, cycles the address or data is stable before the ALEn/RDn/WRn falling edge (>=1)
pSTROBE, 2, cycles ALEn/RDn/WRn are held low (>=1)
pHOLD, 1, cycles after a strobe rises before the next phase (>=1)
pTURN, 1, cycles USB_CEn stays high after a transaction before the next command is accepted (>=1)

Ports:
clk_usb  in  1  sole clock
reset_i  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready at a clk_usb edge
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  8  register address
cmd_len  in  16  number of byte strobes; 0 = address phase only
wr_valid  in  1  write byte available
wr_ready  out  1  high only in WAIT_DATA (combinational from state)
wr_data  in  8  write byte, captured on wr_valid & wr_ready
rd_data  out  8  last byte read; held until the next read sample
rd_valid  out  1  one-cycle pulse per byte read
busy  out  1  high from the cycle after accept until return to IDLE
done  out  1  one-cycle pulse on the first cycle USB_CEn is high again
USB_Addr  out  8  address
USB_D_out  out  8  write data
USB_D_oe  out  1  drive enable for USB_D
USB_D_in  in  8  bus data sampled on reads
USB_ALEn  out  1  address latch strobe, active low
USB_CEn  out  1  chip enable, active low
USB_RDn  out  1  read strobe, active low
USB_WRn  out  1  write strobe, active low

Behaviour:
- All bus outputs, rd_data, rd_valid, busy and done are registered.
- Reset values: USB_CEn, USB_ALEn, USB_RDn and USB_WRn = 1; USB_D_oe = 0; USB_Addr, USB_D_out and rd_data = 0; rd_valid, busy and done = 0; state = IDLE, so cmd_ready = 1 on the cycle after reset.
- Reset asserted mid-transaction: the next edge forces the reset values. No done pulse. The byte counter and captured data are discarded.
- State sequence: IDLE -> A_SETUP(pSETUP) -> A_STROBE(pSTROBE) -> A_HOLD(pHOLD) -> per byte [WAIT_DATA (write only) -> D_SETUP(pSETUP) -> D_STROBE(pSTROBE) -> D_HOLD(pHOLD)] -> TURN(pTURN) -> IDLE.
- A single down-counter times each phase. Each phase lasts exactly the parameter value in cycles.
- On accept, cmd_addr, cmd_write and cmd_len are latched. From the next cycle: USB_CEn = 0 and USB_Addr = addr, both held until TURN.
- USB_ALEn = 0 only during A_STROBE.
- WAIT_DATA: strobes high, USB_D_oe = 0, wr_ready = 1. It stalls indefinitely with USB_CEn low while wr_valid = 0. On accept, wr_data is registered to USB_D_out.
- Write byte: USB_D_oe = 1 throughout D_SETUP, D_STROBE and D_HOLD. USB_WRn = 0 only in D_STROBE. USB_D_oe drops to 0 on leaving D_HOLD.
- Read byte: USB_D_oe = 0. USB_RDn = 0 only in D_STROBE. USB_D_in is sampled on the edge ending the last D_STROBE cycle. rd_valid = 1 and rd_data updated during the first D_HOLD cycle.
- A 16-bit remaining-byte counter is loaded with cmd_len and decremented at the end of each D_HOLD. A value of 0 goes to TURN. cmd_len = 0 skips all byte phases. The counter never wraps.
- USB_RDn and USB_WRn are never low simultaneously, and neither is low while USB_ALEn is low.
- TURN: USB_CEn = 1, USB_Addr held. done = 1 on the first TURN cycle only. busy = 1 through TURN.
- cmd_valid outside IDLE is ignored; no queuing.
- wr_valid outside WAIT_DATA is ignored and never consumes a byte.

Test Plan:
- Reset then idle -> USB_CEn, USB_ALEn, USB_RDn, USB_WRn all 1; USB_D_oe = 0; cmd_ready = 1; busy = 0.
- Defaults, write addr 0x2A, len 2, wr_valid held high with bytes 0x11 then 0x22; cycles counted after accept -> USB_CEn = 0 cycles 1-14; USB_ALEn = 0 cycles 2-3; wr_ready at cycles 5 and 10; USB_WRn = 0 cycles 7-8 with USB_D_out = 0x11 and cycles 12-13 with 0x22; done at cycle 15; cmd_ready = 1 at cycle 16.
- Defaults, read addr 0x05, len 1, USB_D_in = 0xA5 -> USB_RDn = 0 cycles 6-7; rd_valid = 1 with rd_data = 0xA5 at cycle 8; done at cycle 9.
- Write with wr_valid withheld 10 cycles -> USB_CEn stays 0, strobes stay 1, USB_D_oe = 0 throughout; the byte is issued normally once wr_valid rises.
- cmd_len = 0 -> only the address phase (USB_ALEn = 0 cycles 2-3), no RDn/WRn strobes, done at cycle 5.
- reset_i asserted while USB_WRn = 0 -> the next cycle shows all strobes 1, USB_CEn = 1, USB_D_oe = 0, no done pulse; a new command is then accepted normally.
